axi_pipeline_compare: RTL and testbench
=======================================

Name: axi_pipeline_compare

Overview:
- Multi-channel, chunk-pipelined AXI-Stream-style comparator. Each beat's data is compared against NUM_CMP programmable patterns, one CHUNK_SZ slice per stage.
- Each channel has its own bit mask and compare mode: equal, not-equal, unsigned less-than or unsigned greater-or-equal.
- Data, user and per-channel results come out together after NUM_CHUNKS cycles.
- Sits inline in stream paths for header/sync-word detection and threshold gating.
- Config is loaded through a handshake that only completes when the pipeline is empty, so no beat ever sees mixed config.

Parameters:
- DWIDTH, 64, data width; must be a multiple of CHUNK_SZ.
- UWIDTH, 1, sideband user width, passed through unchanged.
- CHUNK_SZ, 16, bits compared per pipeline stage.
- NUM_CMP, 2, number of independent compare channels (1..16).
- NUM_CHUNKS, DWIDTH/CHUNK_SZ, derived localparam; equals the pipeline depth.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config load request.
- cfg_ready  out  1  high when all pipeline stages are invalid.
- cfg_cmp  in  NUM_CMP*DWIDTH  pattern; channel k at [k*DWIDTH +: DWIDTH].
- cfg_mask  in  NUM_CMP*DWIDTH  per-bit enable; 1 = bit participates.
- cfg_mode  in  NUM_CMP*2  per-channel mode: 0 EQ, 1 NE, 2 LTU, 3 GEU.
- s_axi_ready  out  1  input accept.
- s_axi_valid  in  1  input beat valid.
- s_axi_data  in  DWIDTH  input data.
- s_axi_user  in  UWIDTH  input sideband.
- m_axi_ready  in  1  output accept.
- m_axi_valid  out  1  output beat valid.
- m_axi_data  out  DWIDTH  delayed data.
- m_axi_user  out  UWIDTH  delayed sideband.
- m_axi_match  out  NUM_CMP  per-channel result.
- m_axi_any  out  1  OR of m_axi_match.
- m_axi_idx  out  clog2(NUM_CMP) (min 1)  lowest-numbered matching channel; 0 when none match.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All stage valid, data, user and flag registers clear to 0.
  - Outputs: m_axi_valid=0, m_axi_data=0, m_axi_user=0, m_axi_match=0, m_axi_any=0, m_axi_idx=0.
  - Config registers: cmp=0, mask=all ones, mode=EQ.
- Stall/advance:
  - advance = m_axi_ready | ~valid[last].
  - All stages shift together on advance. Bubbles do not collapse except at the last stage.
- Input handshake:
  - s_axi_ready = advance & ~cfg_take.
  - cfg_take = cfg_valid & cfg_ready.
  - A beat is taken when s_axi_valid & s_axi_ready.
- Config handshake:
  - cfg_ready = no stage valid.
  - On cfg_take, the cfg_* inputs are registered at the clock edge.
  - Config takes priority over data in the same cycle: s_axi_ready is low during cfg_take.
  - The first beat after cfg_take uses the new config in every stage.
- Latency: exactly NUM_CHUNKS cycles from input acceptance to m_axi_valid with no backpressure. Throughput is 1 beat/cycle.
- Chunk arithmetic, per channel k, stage i (LSB chunk first):
  - Masked operands: d = data & mask, c = cmp & mask, both on slice [i*CHUNK_SZ +: CHUNK_SZ].
  - eq_c = (d == c); lt_c = (d < c), unsigned.
  - Stage 0: eq = eq_c, lt = lt_c.
  - Stage i: eq_i = eq_{i-1} & eq_c; lt_i = lt_c | (eq_c & lt_{i-1}).
  - Final result by mode: EQ → eq, NE → ~eq, LTU → lt, GEU → ~lt.
  - Mask = 0 for a channel: EQ always true, LTU always false.
- Output validity: m_axi_match, m_axi_any and m_axi_idx are meaningful only while m_axi_valid=1, and hold stable while m_axi_valid & ~m_axi_ready.
- Boundary conditions:
  - NUM_CHUNKS=1: single stage; stage-0 formulas only.
  - Simultaneous final-stage drain and input accept: both occur and the pipeline stays full.
  - cfg_valid held while the pipeline is busy: waits; data keeps flowing; cfg_ready rises once drained.
  - Note: a continuous input stream can starve config. Upstream must gap the stream to reload config.
  - Reset mid-operation: all in-flight beats are discarded and the config returns to reset values.

Decomposition:
- Shared package/header axi_cmp_defs: mode codes CMP_EQ=0, CMP_NE=1, CMP_LTU=2, CMP_GEU=3; mode field width 2.
- Sub-module axi_cmp_chunk:
  - Combinational, one chunk × one channel.
  - Inputs: data slice, cmp slice, mask slice, eq_prev, lt_prev, first flag.
  - Outputs: eq, lt.
  - Instantiated NUM_CHUNKS×NUM_CMP times by generate.
- The top level holds the stage registers, config registers, handshake logic and output priority encoder.

Test Plan:
Config for all tests: DWIDTH=64, CHUNK_SZ=16, NUM_CMP=2.
1. Reset defaults → ch0=EQ, all ones mask, cmp=0. Data 0x0 → match[0]=1 at cycle 4. Data 0x0001_0000_0000_0000 → match[0]=0.
2. Channel 1 as LTU with cmp=0x0000_0001_0000_0000; data 0x0000_0000_FFFF_FFFF → match[1]=1. Data 0x0000_0001_0000_0000 → 0. Same cmp in GEU → inverted.
3. Masked EQ on ch0: mask=0xFFFF_0000_0000_0000, cmp=0xABCD_0000_0000_0000; data 0xABCD_1234_5678_9ABC → match=01, any=1, idx=0. Both channels matching → idx=0.
4. Back-to-back 8 beats with m_axi_ready toggling 1,0,0,1… → no loss or duplication, order preserved, outputs held during stall, s_axi_ready low exactly when last stage valid & ~m_axi_ready.
5. cfg_valid asserted with 3 beats in flight → cfg_ready=0 until drained. In the cfg_take cycle s_axi_ready=0. The next beat is evaluated entirely with the new cmp.
6. aresetn low mid-stream with valid[3]=1 → m_axi_valid=0 immediately, without waiting for a clock edge; config back to defaults; first post-reset beat has latency 4.

Source files
------------

// File: rtl/axi_pipeline_compare_pkg.sv
// Shared definitions for the chunk-pipelined stream comparator:
// compare mode codes and the mode-to-result mapping helper.
package axi_pipeline_compare_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    CMP_EQ  = 2'd0,
    CMP_NE  = 2'd1,
    CMP_LTU = 2'd2,
    CMP_GEU = 2'd3
  } cmp_mode_e;

  // Map the accumulated equal / less-than flags onto the channel result.
  function automatic logic apply_mode(input logic [MODE_W-1:0] mode,
                                      input logic eq,
                                      input logic lt);
    logic res;
    case (mode)
      CMP_EQ:  res = eq;
      CMP_NE:  res = ~eq;
      CMP_LTU: res = lt;
      CMP_GEU: res = ~lt;
      default: res = eq;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi_pipeline_compare_chunk.sv
// One chunk x one channel of the comparator: masks both operands, compares
// the slice and folds the result into the flags carried from lower chunks.
module axi_cmp_chunk
  import axi_pipeline_compare_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] cmp,
  input  logic [W-1:0] mask,
  input  logic         eq_prev,
  input  logic         lt_prev,
  input  logic         first,
  output logic         eq,
  output logic         lt
);

  logic [W-1:0] d_m;
  logic [W-1:0] c_m;
  logic         eq_c;
  logic         lt_c;

  // Chunk compare; higher chunks dominate lt, lower chunk decides on a tie.
  always_comb begin
    d_m  = data & mask;
    c_m  = cmp & mask;
    eq_c = (d_m == c_m);
    lt_c = (d_m < c_m);
    if (first) begin
      eq = eq_c;
      lt = lt_c;
    end else begin
      eq = eq_prev & eq_c;
      lt = lt_c | (eq_c & lt_prev);
    end
  end

endmodule

// File: rtl/axi_pipeline_compare.sv
// Multi-channel chunk-pipelined stream comparator. Each beat is compared
// against NUM_CMP programmable patterns, one CHUNK_SZ slice per stage, and
// leaves with its per-channel results after NUM_CHUNKS cycles. Config is only
// accepted when the pipeline is empty so no beat mixes old and new config.
module axi_pipeline_compare
  import axi_pipeline_compare_pkg::*;
#(
  parameter  int DWIDTH     = 64,
  parameter  int UWIDTH     = 1,
  parameter  int CHUNK_SZ   = 16,
  parameter  int NUM_CMP    = 2,
  localparam int NUM_CHUNKS = DWIDTH / CHUNK_SZ,
  localparam int IDX_W      = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [NUM_CMP*DWIDTH-1:0]   cfg_cmp,
  input  logic [NUM_CMP*DWIDTH-1:0]   cfg_mask,
  input  logic [NUM_CMP*MODE_W-1:0]   cfg_mode,
  output logic                        s_axi_ready,
  input  logic                        s_axi_valid,
  input  logic [DWIDTH-1:0]           s_axi_data,
  input  logic [UWIDTH-1:0]           s_axi_user,
  input  logic                        m_axi_ready,
  output logic                        m_axi_valid,
  output logic [DWIDTH-1:0]           m_axi_data,
  output logic [UWIDTH-1:0]           m_axi_user,
  output logic [NUM_CMP-1:0]          m_axi_match,
  output logic                        m_axi_any,
  output logic [IDX_W-1:0]            m_axi_idx
);

  // Depth of the carried eq/lt flag registers (the last stage registers the
  // final mode-mapped result instead).
  localparam int FLAG_D = (NUM_CHUNKS > 1) ? NUM_CHUNKS - 1 : 1;

  // Config registers
  logic [NUM_CMP*DWIDTH-1:0] cmp_reg;
  logic [NUM_CMP*DWIDTH-1:0] mask_reg;
  logic [NUM_CMP*MODE_W-1:0] mode_reg;

  // Stage registers
  logic [NUM_CHUNKS-1:0] st_valid;
  logic [DWIDTH-1:0]     st_data [NUM_CHUNKS];
  logic [UWIDTH-1:0]     st_user [NUM_CHUNKS];
  logic [NUM_CMP-1:0]    st_eq   [FLAG_D];
  logic [NUM_CMP-1:0]    st_lt   [FLAG_D];

  // Output result registers
  logic [NUM_CMP-1:0] match_reg;
  logic               any_reg;
  logic [IDX_W-1:0]   idx_reg;

  // Combinational chunk results per stage
  logic [NUM_CMP-1:0] ch_eq [NUM_CHUNKS];
  logic [NUM_CMP-1:0] ch_lt [NUM_CHUNKS];
  logic [NUM_CMP-1:0] fin_match;
  logic [IDX_W-1:0]   fin_idx;

  logic advance;
  logic cfg_take;
  logic in_take;

  assign advance     = m_axi_ready | ~st_valid[NUM_CHUNKS-1];
  assign cfg_ready   = ~(|st_valid);
  assign cfg_take    = cfg_valid & cfg_ready;
  assign s_axi_ready = advance & ~cfg_take;
  assign in_take     = s_axi_valid & s_axi_ready;

  assign m_axi_valid = st_valid[NUM_CHUNKS-1];
  assign m_axi_data  = st_data[NUM_CHUNKS-1];
  assign m_axi_user  = st_user[NUM_CHUNKS-1];
  assign m_axi_match = match_reg;
  assign m_axi_any   = any_reg;
  assign m_axi_idx   = idx_reg;

  generate
    for (genvar i = 0; i < NUM_CHUNKS; i++) begin : g_stage
      localparam bit FIRST = (i == 0);
      logic [CHUNK_SZ-1:0] d_slice;
      logic [NUM_CMP-1:0]  eq_prev;
      logic [NUM_CMP-1:0]  lt_prev;
      logic [NUM_CMP-1:0]  eq_out;
      logic [NUM_CMP-1:0]  lt_out;

      if (i == 0) begin : g_first
        assign d_slice = s_axi_data[i*CHUNK_SZ +: CHUNK_SZ];
        assign eq_prev = {NUM_CMP{1'b0}};
        assign lt_prev = {NUM_CMP{1'b0}};
      end else begin : g_next
        assign d_slice = st_data[i-1][i*CHUNK_SZ +: CHUNK_SZ];
        assign eq_prev = st_eq[i-1];
        assign lt_prev = st_lt[i-1];
      end

      for (genvar k = 0; k < NUM_CMP; k++) begin : g_ch
        axi_cmp_chunk #(.W(CHUNK_SZ)) u_chunk (
          .data    (d_slice),
          .cmp     (cmp_reg[k*DWIDTH + i*CHUNK_SZ +: CHUNK_SZ]),
          .mask    (mask_reg[k*DWIDTH + i*CHUNK_SZ +: CHUNK_SZ]),
          .eq_prev (eq_prev[k]),
          .lt_prev (lt_prev[k]),
          .first   (FIRST),
          .eq      (eq_out[k]),
          .lt      (lt_out[k])
        );
      end

      assign ch_eq[i] = eq_out;
      assign ch_lt[i] = lt_out;
    end
  endgenerate

  // Map the last stage's flags onto per-channel results using each mode.
  always_comb begin
    fin_match = {NUM_CMP{1'b0}};
    for (int k = 0; k < NUM_CMP; k++) begin
      fin_match[k] = apply_mode(mode_reg[k*MODE_W +: MODE_W],
                                ch_eq[NUM_CHUNKS-1][k],
                                ch_lt[NUM_CHUNKS-1][k]);
    end
  end

  // Priority encoder: lowest-numbered matching channel, 0 when none match.
  always_comb begin
    fin_idx = {IDX_W{1'b0}};
    for (int k = NUM_CMP - 1; k >= 0; k--) begin
      fin_idx = fin_match[k] ? IDX_W'(k) : fin_idx;
    end
  end

  // Config capture; only happens while the pipeline is empty.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cmp_reg  <= {(NUM_CMP*DWIDTH){1'b0}};
      mask_reg <= {(NUM_CMP*DWIDTH){1'b1}};
      mode_reg <= {(NUM_CMP*MODE_W){1'b0}};
    end else if (cfg_take) begin
      cmp_reg  <= cfg_cmp;
      mask_reg <= cfg_mask;
      mode_reg <= cfg_mode;
    end
  end

  // Pipeline shift: every stage moves together on advance; bubbles propagate.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      st_valid  <= {NUM_CHUNKS{1'b0}};
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        st_data[i] <= {DWIDTH{1'b0}};
        st_user[i] <= {UWIDTH{1'b0}};
      end
      for (int i = 0; i < FLAG_D; i++) begin
        st_eq[i] <= {NUM_CMP{1'b0}};
        st_lt[i] <= {NUM_CMP{1'b0}};
      end
      match_reg <= {NUM_CMP{1'b0}};
      any_reg   <= 1'b0;
      idx_reg   <= {IDX_W{1'b0}};
    end else if (advance) begin
      st_valid[0] <= in_take;
      st_data[0]  <= s_axi_data;
      st_user[0]  <= s_axi_user;
      for (int i = 1; i < NUM_CHUNKS; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_data[i]  <= st_data[i-1];
        st_user[i]  <= st_user[i-1];
      end
      for (int i = 0; i < FLAG_D; i++) begin
        st_eq[i] <= ch_eq[i];
        st_lt[i] <= ch_lt[i];
      end
      match_reg <= fin_match;
      any_reg   <= |fin_match;
      idx_reg   <= fin_idx;
    end
  end

endmodule

// File: tb/tb_axi_pipeline_compare.sv
// Directed self-checking bench for axi_pipeline_compare
// (DWIDTH=64, CHUNK_SZ=16, NUM_CMP=2).
module tb_axi_pipeline_compare;

  logic         clk;
  logic         aresetn;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [127:0] cfg_cmp;
  logic [127:0] cfg_mask;
  logic [3:0]   cfg_mode;
  logic         s_axi_ready;
  logic         s_axi_valid;
  logic [63:0]  s_axi_data;
  logic [0:0]   s_axi_user;
  logic         m_axi_ready;
  logic         m_axi_valid;
  logic [63:0]  m_axi_data;
  logic [0:0]   m_axi_user;
  logic [1:0]   m_axi_match;
  logic         m_axi_any;
  logic [0:0]   m_axi_idx;

  int tests_run;
  int tests_failed;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  axi_pipeline_compare #(
    .DWIDTH(64), .UWIDTH(1), .CHUNK_SZ(16), .NUM_CMP(2)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_cmp(cfg_cmp), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
    .s_axi_ready(s_axi_ready), .s_axi_valid(s_axi_valid),
    .s_axi_data(s_axi_data), .s_axi_user(s_axi_user),
    .m_axi_ready(m_axi_ready), .m_axi_valid(m_axi_valid),
    .m_axi_data(m_axi_data), .m_axi_user(m_axi_user),
    .m_axi_match(m_axi_match), .m_axi_any(m_axi_any), .m_axi_idx(m_axi_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load config: holds cfg_valid until cfg_ready (bounded), then one edge.
  task automatic load_cfg(input logic [127:0] c, input logic [127:0] m, input logic [3:0] md);
    cfg_valid = 1'b1;
    cfg_cmp   = c;
    cfg_mask  = m;
    cfg_mode  = md;
    #1;
    for (int n = 0; n < 20 && !cfg_ready; n++) tick();
    chk("cfg_ready_wait", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Send one beat into an empty pipeline and check latency and results.
  task automatic run_beat(input logic [63:0] d, input logic u, input logic [1:0] em,
                          input logic ei, input string tag);
    m_axi_ready = 1'b1;
    s_axi_valid = 1'b1;
    s_axi_data  = d;
    s_axi_user  = u;
    #1;
    chk({tag, "_s_ready"}, 64'(s_axi_ready), 64'd1);
    tick();
    s_axi_valid = 1'b0;
    for (int n = 1; n < 4; n++) begin
      chk({tag, "_early_valid"}, 64'(m_axi_valid), 64'd0);
      tick();
    end
    chk({tag, "_valid"}, 64'(m_axi_valid), 64'd1);
    chk({tag, "_data"}, m_axi_data, d);
    chk({tag, "_user"}, 64'(m_axi_user), 64'(u));
    chk({tag, "_match"}, 64'(m_axi_match), 64'(em));
    chk({tag, "_any"}, 64'(m_axi_any), 64'(|em));
    chk({tag, "_idx"}, 64'(m_axi_idx), 64'(ei));
    tick();
    chk({tag, "_drained"}, 64'(m_axi_valid), 64'd0);
  endtask

  initial begin
    int          sent;
    int          recv;
    logic        acc;
    logic        stalled;
    logic [63:0] held_d;
    logic [1:0]  held_m;
    logic [1:0]  em;

    tests_run    = 0;
    tests_failed = 0;
    aresetn      = 1'b0;
    cfg_valid    = 1'b0;
    cfg_cmp      = 128'd0;
    cfg_mask     = 128'd0;
    cfg_mode     = 4'd0;
    s_axi_valid  = 1'b0;
    s_axi_data   = 64'd0;
    s_axi_user   = 1'b0;
    m_axi_ready  = 1'b1;

    #23 aresetn = 1'b1;
    tick();

    // Reset state
    chk("rst_valid", 64'(m_axi_valid), 64'd0);
    chk("rst_data",  m_axi_data, 64'd0);
    chk("rst_match", 64'(m_axi_match), 64'd0);
    chk("rst_any",   64'(m_axi_any), 64'd0);
    chk("rst_idx",   64'(m_axi_idx), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);

    // 1. Default config: both channels EQ, cmp 0, full mask
    run_beat(64'h0, 1'b1, 2'b11, 1'b0, "t1_zero");
    run_beat(64'h0001_0000_0000_0000, 1'b0, 2'b00, 1'b0, "t1_top");

    // 2. Channel 1 LTU against 0x0000_0001_0000_0000, then GEU
    load_cfg({64'h0000_0001_0000_0000, 64'h0}, {ONES, ONES}, {2'd2, 2'd0});
    run_beat(64'h0000_0000_FFFF_FFFF, 1'b0, 2'b10, 1'b1, "t2_ltu_lt");
    run_beat(64'h0000_0001_0000_0000, 1'b0, 2'b00, 1'b0, "t2_ltu_eq");
    load_cfg({64'h0000_0001_0000_0000, 64'h0}, {ONES, ONES}, {2'd3, 2'd0});
    run_beat(64'h0000_0000_FFFF_FFFF, 1'b0, 2'b00, 1'b0, "t2_geu_lt");
    run_beat(64'h0000_0001_0000_0000, 1'b0, 2'b10, 1'b1, "t2_geu_eq");

    // 3. Masked EQ on ch0; ch1 mask 0 (NE -> never, EQ -> always, LTU -> never)
    load_cfg({64'h0, 64'hABCD_0000_0000_0000}, {64'h0, 64'hFFFF_0000_0000_0000}, {2'd1, 2'd0});
    run_beat(64'hABCD_1234_5678_9ABC, 1'b1, 2'b01, 1'b0, "t3_masked");
    load_cfg({64'h0, 64'hABCD_0000_0000_0000}, {64'h0, 64'hFFFF_0000_0000_0000}, {2'd0, 2'd0});
    run_beat(64'hABCD_1234_5678_9ABC, 1'b0, 2'b11, 1'b0, "t3_both");
    run_beat(64'hCBCD_1234_5678_9ABC, 1'b0, 2'b10, 1'b1, "t3_ch1_only");
    load_cfg({64'hFFFF_0000_0000_0000, 64'hABCD_0000_0000_0000}, {64'h0, 64'hFFFF_0000_0000_0000}, {2'd2, 2'd0});
    run_beat(64'h0000_1234_5678_9ABC, 1'b0, 2'b00, 1'b0, "t3_ltu_mask0");

    // 4. Eight back-to-back beats with m_axi_ready pattern 1,0,0,1,0,0...
    load_cfg({64'h0, 64'h0}, {64'h0, ONES}, {2'd0, 2'd0});
    sent    = 0;
    recv    = 0;
    stalled = 1'b0;
    held_d  = 64'd0;
    held_m  = 2'd0;
    for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
      m_axi_ready = (cyc % 3 == 0);
      s_axi_valid = (sent < 8);
      s_axi_data  = 64'(sent);
      s_axi_user  = sent[0];
      #1;
      if (stalled) begin
        chk("t4_hold_data", m_axi_data, held_d);
        chk("t4_hold_match", 64'(m_axi_match), 64'(held_m));
        chk("t4_hold_valid", 64'(m_axi_valid), 64'd1);
      end
      chk("t4_s_ready", 64'(s_axi_ready), 64'(!(m_axi_valid && !m_axi_ready)));
      acc = s_axi_valid && s_axi_ready;
      if (m_axi_valid && m_axi_ready) begin
        em = (recv == 0) ? 2'b11 : 2'b10;
        chk("t4_data",  m_axi_data, 64'(recv));
        chk("t4_user",  64'(m_axi_user), 64'(recv % 2));
        chk("t4_match", 64'(m_axi_match), 64'(em));
        chk("t4_idx",   64'(m_axi_idx), (recv == 0) ? 64'd0 : 64'd1);
        recv++;
      end
      stalled = m_axi_valid && !m_axi_ready;
      held_d  = m_axi_data;
      held_m  = m_axi_match;
      tick();
      if (acc) sent++;
    end
    chk("t4_recv_count", 64'(recv), 64'd8);
    chk("t4_sent_count", 64'(sent), 64'd8);
    s_axi_valid = 1'b0;
    m_axi_ready = 1'b1;
    repeat (5) tick();
    chk("t4_no_extra", 64'(m_axi_valid), 64'd0);

    // 5. Config request with three beats in flight
    m_axi_ready = 1'b1;
    s_axi_valid = 1'b1;
    s_axi_data  = 64'h0;
    s_axi_user  = 1'b0;
    repeat (3) tick();
    s_axi_valid = 1'b0;
    cfg_valid   = 1'b1;
    cfg_cmp     = {64'h0, 64'h1234_5678_9ABC_DEF0};
    cfg_mask    = {64'h0, ONES};
    cfg_mode    = 4'd0;
    #1;
    chk("t5_busy_ready", 64'(cfg_ready), 64'd0);
    chk("t5_flow", 64'(s_axi_ready), 64'd1);
    tick();
    chk("t5_old_cfg_valid", 64'(m_axi_valid), 64'd1);
    chk("t5_old_cfg_match", 64'(m_axi_match), 64'd3);
    for (int n = 0; n < 2; n++) begin
      chk("t5_wait_ready", 64'(cfg_ready), 64'd0);
      tick();
    end
    chk("t5_wait_ready_last", 64'(cfg_ready), 64'd0);
    tick();
    chk("t5_drained_ready", 64'(cfg_ready), 64'd1);
    s_axi_valid = 1'b1;
    s_axi_data  = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("t5_take_s_ready", 64'(s_axi_ready), 64'd0);
    tick();
    cfg_valid = 1'b0;
    #1;
    chk("t5_post_take_s_ready", 64'(s_axi_ready), 64'd1);
    tick();
    s_axi_valid = 1'b0;
    chk("t5_busy_again", 64'(cfg_ready), 64'd0);
    repeat (2) tick();
    chk("t5_new_early", 64'(m_axi_valid), 64'd0);
    tick();
    chk("t5_new_valid", 64'(m_axi_valid), 64'd1);
    chk("t5_new_match", 64'(m_axi_match), 64'd3);
    chk("t5_new_idx", 64'(m_axi_idx), 64'd0);
    tick();

    // 6. Reset with a stalled full pipeline
    m_axi_ready = 1'b0;
    s_axi_valid = 1'b1;
    s_axi_data  = 64'h5;
    repeat (4) tick();
    s_axi_valid = 1'b0;
    chk("t6_full", 64'(m_axi_valid), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_async_valid", 64'(m_axi_valid), 64'd0);
    chk("t6_async_data", m_axi_data, 64'd0);
    chk("t6_async_match", 64'(m_axi_match), 64'd0);
    chk("t6_async_cfg_ready", 64'(cfg_ready), 64'd1);
    #2 aresetn = 1'b1;
    tick();
    chk("t6_post_valid", 64'(m_axi_valid), 64'd0);
    run_beat(64'h0, 1'b0, 2'b11, 1'b0, "t6_default_cfg");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
